// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               almost-full/almost-empty thresholds, sticky overflow/underflow
//               flags and a read-valid strobe. Optional macro
//               FIFO_EDGE_DETECT_EN turns wr_en/rd_en into rising-edge
//               requests (one operation per press of a held level).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AFULL    = c_CW'(AFULL_LEVEL);
    localparam logic [c_CW-1:0] c_AEMPTY   = c_CW'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_req;
    logic                  w_rd_req;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_PW-1:0]       w_wr_ptr_nxt;
    logic [c_PW-1:0]       w_rd_ptr_nxt;
    logic                  w_ovf_set;
    logic                  w_udf_set;

`ifdef FIFO_EDGE_DETECT_EN
    logic r_wr_prev;
    logic r_rd_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_prev <= 1'b0;
            r_rd_prev <= 1'b0;
        end else begin
            r_wr_prev <= wr_en;
            r_rd_prev <= rd_en;
        end
    end

    // Request only in the cycle the level is first seen high.
    assign w_wr_req = wr_en & ~r_wr_prev;
    assign w_rd_req = rd_en & ~r_rd_prev;
`else
    assign w_wr_req = wr_en;
    assign w_rd_req = rd_en;
`endif

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign w_wr_acc = w_wr_req & (~w_full | w_rd_req);
    assign w_rd_acc = w_rd_req & ~w_empty;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    assign w_ovf_set = w_wr_req & w_full & ~w_rd_req;
    assign w_udf_set = w_rd_req & w_empty;

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= w_rd_ptr_nxt;
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_rd_acc;

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Set takes priority over a same-cycle clear.
            r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
            r_underflow <= w_udf_set | (r_underflow & ~err_clr);
        end
    end

    assign data_out     = r_data_out;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL);
    assign almost_empty = (r_count <= c_AEMPTY);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Self-checking bench for fifo_param: queue-based model checked
//               every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
`ifdef FIFO_EDGE_DETECT_EN
    localparam int GAP       = 1;
    localparam int BURST_EXP = 1;
`else
    localparam int GAP       = 0;
    localparam int BURST_EXP = 5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic          err_clr;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    fifo_param #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AF),
        .AEMPTY_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a queue holds the stored words in arrival order.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout  = '0;
    bit            m_valid = 1'b0;
    bit            m_ovf   = 1'b0;
    bit            m_udf   = 1'b0;
    bit            m_pw    = 1'b0;
    bit            m_pr    = 1'b0;

    always @(posedge clk) begin
        bit wr, rd, was_full, was_empty;
        if (rst === 1'b1) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_pw    = 1'b0;
            m_pr    = 1'b0;
        end else begin
`ifdef FIFO_EDGE_DETECT_EN
            wr = (wr_en === 1'b1) && !m_pw;
            rd = (rd_en === 1'b1) && !m_pr;
`else
            wr = (wr_en === 1'b1);
            rd = (rd_en === 1'b1);
`endif
            m_pw      = (wr_en === 1'b1);
            m_pr      = (rd_en === 1'b1);
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_valid   = 1'b0;
            if (rd && !was_empty) begin
                m_dout  = mq.pop_front();
                m_valid = 1'b1;
            end
            if (wr && (!was_full || rd)) mq.push_back(data_in);
            if (wr && was_full && !rd) m_ovf = 1'b1;
            else if (err_clr === 1'b1) m_ovf = 1'b0;
            if (rd && was_empty) m_udf = 1'b1;
            else if (err_clr === 1'b1) m_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_count",    count,        mq.size());
            chk("m_full",     full,         mq.size() == DEPTH);
            chk("m_empty",    empty,        mq.size() == 0);
            chk("m_afull",    almost_full,  mq.size() >= AF);
            chk("m_aempty",   almost_empty, mq.size() <= AE);
            chk("m_rd_valid", rd_valid,     m_valid);
            chk("m_data_out", data_out,     m_dout);
            chk("m_overflow", overflow,     m_ovf);
            chk("m_underflow",underflow,    m_udf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        tick();
    endtask

    // With edge detection each operation needs a low cycle before it.
    task automatic op(input bit w, input bit r, input logic [DW-1:0] d);
        if (GAP != 0) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
            tick();
        end
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        tick();
    endtask

    task automatic clear_errors();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_count",  count,        0);
        chk("reset_empty",  empty,        1);
        chk("reset_full",   full,         0);
        chk("reset_aempty", almost_empty, 1);
        chk("reset_afull",  almost_full,  0);
        chk("reset_rvalid", rd_valid,     0);

        // Basic write then read, in order.
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b0, 8'(8'h11 + i));
            chk("t1_wcount", count, i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t1_rdata",  data_out, 32'h11 + i);
            chk("t1_rvalid", rd_valid, 1);
            chk("t1_rcount", count,    3 - i);
        end
        idle();
        chk("t1_rvalid_drop", rd_valid, 0);
        chk("t1_empty",       empty,    1);

        // Fill to full, overflow, clear.
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 8'(8'h20 + i));
            chk("t2_afull", almost_full, (i + 1) >= AF);
        end
        chk("t2_full",  full,  1);
        chk("t2_count", count, 16);
        op(1'b1, 1'b0, 8'hEE);
        chk("t2_overflow", overflow, 1);
        chk("t2_ovf_count", count, 16);
        idle();
        clear_errors();
        chk("t2_ovf_clear", overflow, 0);

        // Simultaneous read/write while full.
        op(1'b1, 1'b1, 8'hAA);
        chk("t3_count",  count,    16);
        chk("t3_rdata",  data_out, 32'h20);
        chk("t3_rvalid", rd_valid, 1);
        chk("t3_no_ovf", overflow, 0);
        idle();
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t3_drain", data_out, (i < 15) ? (32'h21 + i) : 32'hAA);
        end
        idle();
        chk("t3_empty", empty, 1);

        // Simultaneous read/write while empty.
        op(1'b1, 1'b1, 8'h5C);
        chk("t4_count",     count,     1);
        chk("t4_underflow", underflow, 1);
        chk("t4_rvalid",    rd_valid,  0);
        idle();
        clear_errors();
        chk("t4_udf_clear", underflow, 0);
        op(1'b0, 1'b1, 8'h00);
        chk("t4_rdata",  data_out, 32'h5C);
        chk("t4_rvalid", rd_valid, 1);
        idle();

        // Pointer wrap: fill 10, drain 10, fill 12, drain 12.
        for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t5_rdata_a", data_out, 32'h30 + i);
        end
        for (int i = 0; i < 12; i++) op(1'b1, 1'b0, 8'(8'h40 + i));
        chk("t5_count12", count, 12);
        for (int i = 0; i < 12; i++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t5_rdata_b", data_out,     32'h40 + i);
            chk("t5_aempty",  almost_empty, (11 - i) <= AE);
        end
        idle();

        // Held level burst, then reset mid-burst.
        op(1'b0, 1'b1, 8'h00);
        chk("t6_underflow", underflow, 1);
        idle();
        wr_en   = 1'b1;
        data_in = 8'h77;
        repeat (5) tick();
        wr_en = 1'b0;
        tick();
        chk("t6_burst_count", count, BURST_EXP);
        wr_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        chk("t6_rst_count",  count,        0);
        chk("t6_rst_empty",  empty,        1);
        chk("t6_rst_full",   full,         0);
        chk("t6_rst_aempty", almost_empty, 1);
        chk("t6_rst_afull",  almost_full,  0);
        chk("t6_rst_udf",    underflow,    0);
        chk("t6_rst_ovf",    overflow,     0);
        chk("t6_rst_rvalid", rd_valid,     0);
        chk("t6_rst_dout",   data_out,     0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. It generalises data width and depth. It adds:
- simultaneous read/write in one cycle
- an occupancy count output
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a read-valid strobe

It sits between a producer (e.g. the debounced switch/button input path) and a consumer, all in one clock domain.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out in bits (>=1).
DEPTH, 16, number of storage entries (>=2, need not be a power of two).
AFULL_LEVEL, 14, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH).
AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL (0..DEPTH-1).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset.
data_in  input  DATA_WIDTH  write data.
wr_en  input  1  write request.
rd_en  input  1  read request.
err_clr  input  1  clears sticky overflow/underflow.
data_out  output  DATA_WIDTH  registered read data.
rd_valid  output  1  data_out updated this cycle.
count  output  $clog2(DEPTH+1)  current occupancy.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AFULL_LEVEL.
almost_empty  output  1  count <= AEMPTY_LEVEL.
overflow  output  1  sticky: a write was attempted while full and not accepted.
underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high, sampled on the rising edge of clk.
  - rst has priority over every other input.
- Reset values:
  - Write pointer, read pointer, count, data_out, rd_valid, overflow and underflow are all 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_LEVEL >= 1).
- Memory contents are not reset.
- Accept rules, evaluated on the registered state before the edge:
  - wr_acc = wr_en & (~full | rd_en).
  - rd_acc = rd_en & ~empty.
- Write path:
  - wr_acc writes data_in to mem[wr_ptr].
  - wr_ptr increments, wrapping from DEPTH-1 to 0 by explicit compare (not power-of-two masking).
- Read path:
  - rd_acc loads mem[rd_ptr] into data_out and sets rd_valid=1 for exactly the next cycle.
  - rd_ptr increments with the same wrap rule.
  - When no read is accepted, rd_valid=0 and data_out holds its last value.
  - Read latency is 1 cycle from the rd_en edge to data_out/rd_valid.
- Count update:
  - count += 1 on wr_acc only.
  - count -= 1 on rd_acc only.
  - count is unchanged on both or neither.
- Simultaneous read and write:
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: write accepted, read rejected, underflow set, count becomes 1. No read-through of the incoming word.
  - Otherwise: both accepted.
- Error flags:
  - overflow is set on wr_en & full & ~rd_en.
  - underflow is set on rd_en & empty.
  - Both are cleared by err_clr, or by rst.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Rejected operations never modify the pointers, count or memory.
- Status outputs full, empty, almost_full and almost_empty are combinational decodes of the count register. They change in the same cycle as count.
- Reset mid-operation: a pending request in the reset cycle is discarded and the FIFO is empty on the next cycle.

Optional Feature:
Macro FIFO_EDGE_DETECT_EN.
- When defined:
  - wr_en and rd_en each pass through an internal registered rising-edge detector (previous-value register, reset to 0).
  - A request is generated only in the cycle where the input is 1 and was 0 on the previous edge.
  - A level held for N cycles therefore produces exactly one operation. Intended for debounced push-button drivers.
  - This adds no latency beyond the detector: the operation happens on the edge where the rise is first sampled.
- When undefined: wr_en and rd_en are level-sensitive, giving one operation per cycle while high.

Test Plan:
1. Reset, then write 0x11..0x14 on 4 consecutive cycles, then read 4 → count steps 1,2,3,4,3,2,1,0. data_out=0x11,0x12,0x13,0x14, each with rd_valid one cycle after rd_en. empty=1 at end.
2. DEPTH=16: 16 writes → full=1, count=16, almost_full from count 14. 17th write → rejected, overflow=1, data unchanged. err_clr → overflow=0.
3. Full FIFO, wr_en=rd_en=1 with data_in=0xAA → count stays 16, data_out=oldest word. 0xAA is read back as the 16th subsequent read.
4. Empty FIFO, wr_en=rd_en=1 with 0x5C → count=1, underflow=1, rd_valid=0. The next read returns 0x5C.
5. Fill 10, drain 10, fill 12 with DEPTH=16 → pointer wrap past entry 15. Read order matches write order exactly; almost_empty toggles at count 3→2.
6. With FIFO_EDGE_DETECT_EN, hold wr_en high 5 cycles → count=1. Without the macro → count=5. Assert rst mid-burst → count=0, flags at reset values the next cycle.
